// File: rtl/cpu_mc_pkg.sv
// rtl/cpu_mc_pkg.sv - shared opcodes, ALU control codes and FSM states for cpu_mc
// Purpose: single source of truth for instruction decode constants.
// Contents: opcode localparams, ALUctl encodings, state_e enum,
//           op_to_aluctl() and op_writes_back() decode helpers.
package cpu_mc_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_LI   = 3'b101;
  localparam logic [2:0] OP_NOP  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    WB     = 2'd2,
    HALTED = 2'd3
  } state_e;

  // Non-ALU opcodes (LI/NOP/HALT) map to ADD; their ALU result is ignored.
  function automatic logic [2:0] op_to_aluctl(input logic [2:0] op);
    logic [2:0] ctl;
    ctl = ALU_ADD;
    case (op)
      OP_ADD:  ctl = ALU_ADD;
      OP_SUB:  ctl = ALU_SUB;
      OP_AND:  ctl = ALU_AND;
      OP_OR:   ctl = ALU_OR;
      OP_SLT:  ctl = ALU_SLT;
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

  // Opcodes 000..101 (the five ALU ops plus LI) update the register file.
  function automatic logic op_writes_back(input logic [2:0] op);
    return (op <= OP_LI);
  endfunction

endpackage

// File: rtl/cpu_mc_alu.sv
// rtl/cpu_mc_alu.sv - combinational W-bit ALU for cpu_mc
// Purpose: ADD/SUB/AND/OR/SLT with signed-overflow detection for ADD/SUB.
// Ports:
//   ALUctl   in  3  operation select (ALU_* codes from cpu_mc_pkg)
//   A, B     in  W  operands
//   ALUOut   out W  result, modulo 2^W; SLT gives 0/1 zero-extended
//   Overflow out 1  signed overflow of ADD/SUB, 0 for every other op
module alu_w
  import cpu_mc_pkg::*;
#(
  parameter int W          = 4,
  parameter bit SIGNED_SLT = 1'b0
) (
  input  logic [2:0]   ALUctl,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] ALUOut,
  output logic         Overflow
);

  logic [W-1:0] sum;
  logic [W-1:0] diff;
  logic         lt;

  always_comb begin
    sum  = A + B;
    diff = A - B;
    if (SIGNED_SLT) begin
      lt = ($signed(A) < $signed(B));
    end else begin
      lt = (A < B);
    end

    ALUOut   = '0;
    Overflow = 1'b0;
    case (ALUctl)
      ALU_ADD: begin
        ALUOut   = sum;
        // Like-signed operands producing an opposite-signed sum.
        Overflow = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]);
      end
      ALU_SUB: begin
        ALUOut   = diff;
        // Unlike-signed operands where the result sign leaves A's sign.
        Overflow = (A[W-1] != B[W-1]) && (diff[W-1] != A[W-1]);
      end
      ALU_AND: ALUOut = A & B;
      ALU_OR:  ALUOut = A | B;
      ALU_SLT: ALUOut = {{(W-1){1'b0}}, lt};
      default: ALUOut = '0;
    endcase
  end

endmodule

// File: rtl/cpu_mc.sv
// rtl/cpu_mc.sv - parametrised multi-cycle CPU (FETCH/EXEC/WB) with write-back strobe
// Purpose: fetches one instruction per handshake and retires it through a
//          fixed three-state sequence; HALT parks the core until reset.
// Ports:
//   CLK          in  1   clock
//   RST_N        in  1   asynchronous active-low reset
//   Instruction  in  IW  {OP[2:0], RS, RT, RD}; LI uses {RS,RT} as immediate
//   instr_valid  in  1   Instruction valid
//   instr_ready  out 1   core in FETCH and able to accept
//   WriteData    out W   last written value (held between write-backs)
//   wb_valid     out 1   one-cycle pulse per register write
//   wb_reg       out RA  destination of the last write-back
//   zero         out 1   last written value is zero
//   overflow     out 1   signed overflow of last write-back (ADD/SUB only)
//   halted       out 1   HALT has executed
module cpu_mc
  import cpu_mc_pkg::*;
#(
  parameter  int W          = 4,
  parameter  int NREG       = 4,
  parameter  bit SIGNED_SLT = 1'b0,
  localparam int RA         = $clog2(NREG),
  localparam int IW         = 3 + 3 * RA
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [IW-1:0] Instruction,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic [W-1:0]  WriteData,
  output logic          wb_valid,
  output logic [RA-1:0] wb_reg,
  output logic          zero,
  output logic          overflow,
  output logic          halted
);

  state_e        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [W-1:0]  regs_q [NREG];
  logic [W-1:0]  regs_d [NREG];
  logic [W-1:0]  res_q, res_d;
  logic          res_ovf_q, res_ovf_d;
  logic [W-1:0]  wdata_q, wdata_d;
  logic          wb_valid_q, wb_valid_d;
  logic [RA-1:0] wb_reg_q, wb_reg_d;
  logic          zero_q, zero_d;
  logic          ovf_q, ovf_d;

  // Instruction fields, decoded from the IR so operands stay stable
  // through EXEC and WB regardless of what the source drives.
  logic [2:0]      op;
  logic [RA-1:0]   rs, rt, rd;
  logic [2*RA-1:0] imm;
  logic [W-1:0]    imm_ext;
  logic [W-1:0]    op_a, op_b;
  logic [2:0]      aluctl;
  logic [W-1:0]    alu_out;
  logic            alu_ovf;

  assign op     = ir_q[IW-1:IW-3];
  assign rs     = ir_q[3*RA-1:2*RA];
  assign rt     = ir_q[2*RA-1:RA];
  assign rd     = ir_q[RA-1:0];
  assign imm    = ir_q[IW-4:RA];
  assign op_a   = regs_q[rs];
  assign op_b   = regs_q[rt];
  assign aluctl = op_to_aluctl(op);

  // Immediate is 2*RA bits wide: truncate or zero-extend to fit W.
  if (2 * RA >= W) begin : g_imm_trunc
    assign imm_ext = imm[W-1:0];
  end else begin : g_imm_zext
    assign imm_ext = {{(W - 2 * RA){1'b0}}, imm};
  end

  alu_w #(
    .W          (W),
    .SIGNED_SLT (SIGNED_SLT)
  ) u_alu (
    .ALUctl   (aluctl),
    .A        (op_a),
    .B        (op_b),
    .ALUOut   (alu_out),
    .Overflow (alu_ovf)
  );

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    regs_d     = regs_q;
    res_d      = res_q;
    res_ovf_d  = res_ovf_q;
    wdata_d    = wdata_q;
    wb_valid_d = 1'b0;
    wb_reg_d   = wb_reg_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;

    case (state_q)
      FETCH: begin
        if (instr_valid) begin
          ir_d    = Instruction;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d     = (op == OP_LI) ? imm_ext : alu_out;
        res_ovf_d = ((op == OP_ADD) || (op == OP_SUB)) ? alu_ovf : 1'b0;
        state_d   = (op == OP_HALT) ? HALTED : WB;
      end
      WB: begin
        if (op_writes_back(op)) begin
          regs_d[rd] = res_q;
          wdata_d    = res_q;
          wb_reg_d   = rd;
          zero_d     = (res_q == '0);
          // Non-ADD/SUB results carry a 0 overflow bit, which clears the flag.
          ovf_d      = res_ovf_q;
          wb_valid_d = 1'b1;
        end
        state_d = FETCH;
      end
      HALTED: state_d = HALTED;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= FETCH;
      ir_q       <= '0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      res_q      <= '0;
      res_ovf_q  <= 1'b0;
      wdata_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_reg_q   <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      regs_q     <= regs_d;
      res_q      <= res_d;
      res_ovf_q  <= res_ovf_d;
      wdata_q    <= wdata_d;
      wb_valid_q <= wb_valid_d;
      wb_reg_q   <= wb_reg_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
    end
  end

  // Ready and halted decode straight from state, so they follow reset
  // immediately rather than waiting for a clock edge.
  assign instr_ready = (state_q == FETCH);
  assign halted      = (state_q == HALTED);
  assign WriteData   = wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_reg      = wb_reg_q;
  assign zero        = zero_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_cpu_mc.sv
// tb/tb_cpu_mc.sv - self-checking bench for cpu_mc (W=4/NREG=4 and W=8/NREG=8 signed)
module tb_cpu_mc;

  logic        CLK   = 1'b0;
  logic        RST_N = 1'b0;
  logic        sel   = 1'b0;
  logic        valid = 1'b0;
  logic [11:0] instr = '0;

  always #5 CLK = ~CLK;

  logic valid4, valid8;
  assign valid4 = valid & ~sel;
  assign valid8 = valid & sel;

  logic       rdy4, wbv4, z4, o4, h4;
  logic [3:0] wd4;
  logic [1:0] wr4;
  logic       rdy8, wbv8, z8, o8, h8;
  logic [7:0] wd8;
  logic [2:0] wr8;

  cpu_mc #(.W(4), .NREG(4), .SIGNED_SLT(1'b0)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .Instruction(instr[8:0]), .instr_valid(valid4),
    .instr_ready(rdy4), .WriteData(wd4), .wb_valid(wbv4), .wb_reg(wr4),
    .zero(z4), .overflow(o4), .halted(h4)
  );

  cpu_mc #(.W(8), .NREG(8), .SIGNED_SLT(1'b1)) dut8 (
    .CLK(CLK), .RST_N(RST_N), .Instruction(instr), .instr_valid(valid8),
    .instr_ready(rdy8), .WriteData(wd8), .wb_valid(wbv8), .wb_reg(wr8),
    .zero(z8), .overflow(o8), .halted(h8)
  );

  logic       a_rdy, a_wbv, a_z, a_o, a_h;
  logic [7:0] a_wd;
  logic [2:0] a_wr;
  assign a_rdy = sel ? rdy8 : rdy4;
  assign a_wbv = sel ? wbv8 : wbv4;
  assign a_z   = sel ? z8 : z4;
  assign a_o   = sel ? o8 : o4;
  assign a_h   = sel ? h8 : h4;
  assign a_wd  = sel ? wd8 : {4'b0, wd4};
  assign a_wr  = sel ? wr8 : {1'b0, wr4};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {int due; longint val; int rd; bit z; bit o;} wb_t;
  typedef struct {longint wd; bit z; bit o;} cap_t;

  int     mw = 4, mra = 2;
  bit     msgn = 1'b0;
  longint m_reg [8];
  int     m_busy = 0;
  bit     m_halt = 1'b0;
  int     m_halt_at = 0;
  int     cyc = 0;
  int     m_acc_cnt = 0;
  bit     m_rdy;
  wb_t    exp_q [$];
  cap_t   cap_q [$];
  longint last_wd = 0;
  int     last_rd = 0;
  bit     last_z = 1'b0, last_o = 1'b0;

  function automatic longint sx(input longint v, input int w);
    if (v[w-1]) return v - (longint'(1) << w);
    return v;
  endfunction

  task automatic model_exec(input longint ins);
    longint mask, a, b, r, full, smax, smin;
    int op, rs, rt, rd;
    bit o, wr;
    mask = (longint'(1) << mw) - 1;
    smax = (longint'(1) << (mw - 1)) - 1;
    smin = -(longint'(1) << (mw - 1));
    op = int'((ins >> (3 * mra)) & 7);
    rs = int'((ins >> (2 * mra)) & ((1 << mra) - 1));
    rt = int'((ins >> mra) & ((1 << mra) - 1));
    rd = int'(ins & ((1 << mra) - 1));
    a = m_reg[rs];
    b = m_reg[rt];
    r = 0; o = 1'b0; wr = 1'b1;
    case (op)
      0: begin full = sx(a, mw) + sx(b, mw); r = (a + b) & mask; o = (full > smax) || (full < smin); end
      1: begin full = sx(a, mw) - sx(b, mw); r = (a - b) & mask; o = (full > smax) || (full < smin); end
      2: r = a & b;
      3: r = a | b;
      4: r = msgn ? longint'(sx(a, mw) < sx(b, mw)) : longint'(a < b);
      5: r = ((ins >> mra) & ((longint'(1) << (2 * mra)) - 1)) & mask;
      6: wr = 1'b0;
      default: begin wr = 1'b0; m_halt = 1'b1; m_halt_at = cyc + 1; end
    endcase
    if (wr) begin
      m_reg[rd] = r;
      exp_q.push_back('{cyc + 2, r, rd, (r == 0), o});
    end
  endtask

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 8; i++) m_reg[i] = 0;
      m_busy = 0; m_halt = 1'b0; m_halt_at = 0;
      exp_q.delete();
      last_wd = 0; last_rd = 0; last_z = 1'b0; last_o = 1'b0;
    end else begin
      cyc++;
      m_rdy = (m_busy == 0) && !m_halt;
      if (m_busy > 0) m_busy--;
      if (m_rdy && valid) begin
        m_acc_cnt++;
        m_busy = 2;
        model_exec(longint'(instr));
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit  ew;
  wb_t e;
  always @(negedge CLK) begin
    if (RST_N) begin
      ew = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      if (ew) begin
        e = exp_q.pop_front();
        last_wd = e.val; last_rd = e.rd; last_z = e.z; last_o = e.o;
      end
      chk("wb_valid", a_wbv, ew);
      if (a_wbv) cap_q.push_back('{longint'(a_wd), a_z, a_o});
      chk("WriteData", a_wd, last_wd);
      chk("wb_reg", a_wr, last_rd);
      chk("zero", a_z, last_z);
      chk("overflow", a_o, last_o);
      chk("halted", a_h, m_halt && (cyc >= m_halt_at));
      chk("instr_ready", a_rdy, (m_busy == 0) && !m_halt);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [11:0] enc(input int op, input int rs, input int rt, input int rd);
    return 12'((op << (3 * mra)) | (rs << (2 * mra)) | (rt << mra) | rd);
  endfunction

  function automatic logic [11:0] enc_li(input int imm, input int rd);
    return 12'((5 << (3 * mra)) | (imm << mra) | rd);
  endfunction

  task automatic issue(input logic [11:0] ins);
    int start;
    bit got;
    @(negedge CLK);
    instr = ins;
    valid = 1'b1;
    start = m_acc_cnt;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(posedge CLK);
      #1;
      got = (m_acc_cnt != start);
    end
    if (!got) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    @(negedge CLK);
    valid = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_reset();
    @(posedge CLK);
    #1;
    valid = 1'b0;
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic cap_expect(input string nm, input int idx, input longint wd, input int z, input int o);
    if (idx >= cap_q.size()) begin
      chk({nm, "_count"}, cap_q.size(), idx + 1);
    end else begin
      chk($sformatf("%s_wd%0d", nm, idx), cap_q[idx].wd, wd);
      if (z >= 0) chk($sformatf("%s_zero%0d", nm, idx), cap_q[idx].z, z);
      if (o >= 0) chk($sformatf("%s_ovf%0d", nm, idx), cap_q[idx].o, o);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  longint prog_a [10] = '{7, 5, 2, 10, 15, 10, 1, 11, 2, 0};

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_ready", rdy4, 1);
    chk("rst_wb_valid", wbv4, 0);
    chk("rst_WriteData", wd4, 0);
    chk("rst_wb_reg", wr4, 0);
    chk("rst_zero", z4, 0);
    chk("rst_overflow", o4, 0);
    chk("rst_halted", h4, 0);
    chk("rst_ready8", rdy8, 1);
    #1 RST_N = 1'b1;

    // Program from the test plan, back-to-back with valid held high.
    cap_q.delete();
    issue(enc_li(7, 1));
    issue(enc_li(5, 2));
    issue(enc(1, 1, 2, 3));
    issue(enc_li(10, 3));
    issue(enc(3, 2, 3, 2));
    issue(enc(2, 2, 3, 3));
    issue(enc(4, 3, 2, 2));
    issue(enc(0, 3, 2, 2));
    issue(enc(0, 1, 2, 3));
    issue(enc(4, 2, 3, 1));
    idle(3);
    chk("progA_count", cap_q.size(), 10);
    for (int i = 0; i < 10; i++) cap_expect("progA", i, prog_a[i], -1, -1);
    cap_expect("progA", 8, 2, 0, -1);
    cap_expect("progA", 9, 0, 1, -1);

    // Flags.
    cap_q.delete();
    issue(enc_li(7, 1));
    issue(enc_li(1, 2));
    issue(enc(0, 1, 2, 3));
    issue(enc(1, 1, 1, 3));
    idle(3);
    cap_expect("flags", 2, 8, 0, 1);
    cap_expect("flags", 3, 0, 1, 0);

    // Handshake: stall, then NOP, then read back R2 and R1 unchanged.
    cap_q.delete();
    issue(enc_li(9, 2));
    idle(5);
    issue(enc(6, 0, 0, 0));
    idle(3);
    issue(enc(3, 2, 2, 2));
    issue(enc(3, 1, 1, 1));
    idle(3);
    chk("hs_count", cap_q.size(), 3);
    cap_expect("hs", 0, 9, -1, -1);
    cap_expect("hs", 1, 9, -1, -1);
    cap_expect("hs", 2, 7, -1, -1);

    // HALT, then keep offering an instruction.
    cap_q.delete();
    issue(enc(7, 0, 0, 0));
    @(negedge CLK);
    instr = enc_li(3, 1);
    valid = 1'b1;
    repeat (10) @(negedge CLK);
    chk("halt_halted", h4, 1);
    chk("halt_ready", rdy4, 0);
    chk("halt_no_wb", cap_q.size(), 0);
    pulse_reset();
    @(negedge CLK);
    chk("post_rst_halted", h4, 0);
    chk("post_rst_ready", rdy4, 1);
    for (int k = 0; k < 4; k++) issue(enc(3, k, k, k));
    idle(3);
    for (int k = 0; k < 4; k++) cap_expect("rst_regs", k, 0, 1, 0);

    // Reset while li R1,7 is in EXEC.
    cap_q.delete();
    issue(enc_li(7, 1));
    valid = 1'b0;
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    #1 RST_N = 1'b1;
    issue(enc(0, 1, 1, 2));
    idle(3);
    chk("abort_count", cap_q.size(), 1);
    cap_expect("abort", 0, 0, 1, 0);

    // Wide, signed-compare instance.
    @(posedge CLK);
    #1 RST_N = 1'b0;
    sel = 1'b1; mw = 8; mra = 3; msgn = 1'b1;
    repeat (2) @(negedge CLK);
    #1 RST_N = 1'b1;
    cap_q.delete();
    issue(enc_li(63, 1));
    issue(enc_li(1, 2));
    issue(enc(1, 2, 1, 3));
    issue(enc(4, 3, 1, 4));
    idle(3);
    chk("w8_count", cap_q.size(), 4);
    cap_expect("w8", 0, 63, 0, -1);
    cap_expect("w8", 1, 1, 0, -1);
    cap_expect("w8", 2, 194, 0, 0);
    cap_expect("w8", 3, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_mc.md
# cpu_mc

Parametrised multi-cycle successor to the 4-bit single-cycle CPU.
- Configurable data width, register count and signed/unsigned compare.
- Fetches instructions over a valid/ready handshake and executes each one in a fixed three-state FETCH/EXEC/WB sequence.
- Adds NOP, HALT, zero and overflow flags, and a write-back strobe.
- Sits between an instruction source (testbench or instruction ROM sequencer) and any write-back observer.

## Interface
- W, 4: data width, ≥ 2.
- NREG, 4: register count, power of two, ≥ 2.
- RA, $clog2(NREG): register address width, derived.
- IW, 3+3*RA: instruction width, derived.
- SIGNED_SLT, 0: 1 = two's-complement compare for SLT, 0 = unsigned compare.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  reset; asynchronous, active-low.
- Instruction  in  IW  instruction word; fields are OP[IW-1:IW-3], RS[3RA-1:2RA], RT[2RA-1:RA], RD[RA-1:0].
- instr_valid  in  1  Instruction is valid.
- instr_ready  out  1  block accepts an instruction this cycle.
- WriteData  out  W  value written back in the current WB cycle; holds between write-backs.
- wb_valid  out  1  single-cycle pulse when a register is written.
- wb_reg  out  RA  destination of the current write-back.
- zero  out  1  last written value == 0.
- overflow  out  1  signed overflow of the last ADD/SUB; cleared by any other write-back.
- halted  out  1  HALT has executed.

## Operation
Opcodes and their ALUctl values:
- 000 ADD (ALUctl 010).
- 001 SUB (110).
- 010 AND (000).
- 011 OR (001).
- 100 SLT (111).
- 101 LI.
- 110 NOP.
- 111 HALT.

Instruction semantics:
- R-type: R[RD] = R[RS] op R[RT].
  - Results are modulo 2^W.
  - SLT writes 1 or 0, zero-extended to W bits.
- LI: R[RD] = imm, where imm = Instruction[IW-4:RA] (2*RA bits).
  - Zero-extended to W when 2*RA < W.
  - Truncated to its low W bits when 2*RA > W.
- overflow for ADD/SUB: operand sign bits (equal for ADD, differing for SUB) differ from the result sign bit.
- NOP: passes through all states and does not write back; wb_valid stays 0.
- HALT: enters HALTED; instr_ready stays 0 until reset.

Register file:
- NREG × W registers, all reset to 0, all writable; there is no hardwired zero register.
- Reads are combinational from the IR fields.

State machine:
- FETCH: instr_ready = 1. On instr_valid & instr_ready, latch Instruction into IR and go to EXEC. Otherwise stay in FETCH.
- EXEC: register operands are read and the ALU result is captured in a result register, together with its overflow bit. Go to WB, or to HALTED if OP = HALT.
- WB: for write-back opcodes, write R[RD], drive WriteData, wb_reg, zero and overflow, and pulse wb_valid. Go to FETCH.
- HALTED: terminal state; only RST_N leaves it.

## Timing
- Reset values:
  - State FETCH.
  - IR = 0, all registers = 0, result register = 0.
  - WriteData = 0, wb_reg = 0.
  - wb_valid, zero, overflow and halted = 0.
  - instr_ready = 1 as soon as RST_N is low, since it decodes from state.
- Latency: an instruction accepted at edge n writes back at edge n+2; wb_valid is high during the cycle following edge n+2.
- Throughput: one instruction per 3 cycles. instr_ready is low in EXEC, WB and HALTED.
- An instruction presented while instr_ready = 0 is not consumed; the source must hold it.
- Read-after-write: a strictly sequential FETCH/EXEC/WB order means no hazards and no bypass network.
- RS = RT = RD is allowed; operands are read in EXEC, before the write in WB.
- Asserting RST_N mid-instruction (EXEC or WB) aborts it: no register write, outputs return to their reset values.
- instr_valid held high continuously: back-to-back accepts occur every third edge.

## Structure
- Package cpu_mc_pkg holds:
  - opcode localparams;
  - ALUctl encodings;
  - the state enum {FETCH, EXEC, WB, HALTED}.
- Sub-module alu_w holds the ALU:
  - parameters W and SIGNED_SLT;
  - inputs ALUctl, A and B;
  - outputs ALUOut and Overflow;
  - purely combinational.
- Register file, IR and FSM stay in cpu_mc.

## Test plan
- W=4, NREG=4, unsigned compare: run this program; every wb_valid pulse and value must match, with each write-back 2 cycles after its accept.
  - li R1,7 → WriteData 7.
  - li R2,5 → 5.
  - sub R3,R1,R2 → 2.
  - li R3,10 → 10.
  - or R2,R2,R3 → 15.
  - and R3,R2,R3 → 10.
  - slt R2,R3,R2 → 1.
  - add R2,R3,R2 → 11.
  - add R3,R1,R2 → 2 (zero = 0).
  - slt R1,R2,R3 → 0 (zero = 1).
- Flags: li R1,7; li R2,1; add R3,R1,R2 → WriteData 8, overflow 1. Then sub R3,R1,R1 → 0, zero 1, overflow 0.
- Handshake: hold instr_valid = 0 for 5 cycles after an accept → no wb_valid, register contents unchanged. Then raise it with NOP → instr_ready drops for 2 cycles and no wb_valid pulse occurs.
- HALT followed by instr_valid held high → halted = 1 and instr_ready = 0 indefinitely. Pulse RST_N → halted = 0, instr_ready = 1, all registers read 0.
- Reset while in EXEC of li R1,7 → no wb_valid. A following add R2,R1,R1 writes 0.
- W=8, NREG=8, SIGNED_SLT=1 (IW=12): li R1,63 → WriteData 63. A second LI with immediate 1 into R2, then sub R3,R2,R1 → 194 (−62). Then slt R4,R3,R1 → 1.
